// File: rtl/req_dispatch.sv
// Single-outstanding request dispatcher: pulses one downstream request, waits for its done edge.
// Optional WAIT timeout enabled by defining REQ_DISPATCH_TIMEOUT_EN.
module req_dispatch #(
    parameter int unsigned REQ_NUMBER     = 2,
    parameter int unsigned SEL_WIDTH      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [REQ_NUMBER-1:0] reqs,
    input  logic [REQ_NUMBER-1:0] dones,
    output logic                  busy,
    output logic                  fin,
    output logic                  err
);

    if (REQ_NUMBER < 1 || REQ_NUMBER > 16 || (2 ** SEL_WIDTH) < REQ_NUMBER ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("req_dispatch: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

    state_e                state_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [REQ_NUMBER-1:0] dones_q;
    logic [REQ_NUMBER-1:0] done_rise;
    logic [REQ_NUMBER-1:0] sel_onehot;
    logic                  pending_q;
    logic                  sel_rise;
    logic                  sel_valid;
`ifdef REQ_DISPATCH_TIMEOUT_EN
    logic [15:0]           cnt_q;
`endif

    assign done_rise = dones & ~dones_q;

    // sel_onehot decodes the live sel (empty when out of range); sel_rise watches the latched one
    always_comb begin
        sel_rise   = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < int'(REQ_NUMBER); i++) begin
            if (sel_q == SEL_WIDTH'(i)) sel_rise = done_rise[i];
            if (sel == SEL_WIDTH'(i)) sel_onehot[i] = 1'b1;
        end
    end

    assign sel_valid = |sel_onehot;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            reqs      <= '0;
            fin       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            sel_q     <= '0;
            dones_q   <= '0;
            pending_q <= 1'b0;
`ifdef REQ_DISPATCH_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            dones_q <= dones;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sel_q <= sel;
                        busy  <= 1'b1;
                        if (sel_valid) begin
                            state_q <= StIssue;
                            reqs    <= sel_onehot;
                        end else begin
                            state_q <= StFin;
                            fin     <= 1'b1;
                            err     <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    reqs    <= '0;
                    state_q <= StWait;
                    // A done edge coincident with the request must not be lost
                    if (sel_rise) pending_q <= 1'b1;
`ifdef REQ_DISPATCH_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWait: begin
                    if (sel_rise || pending_q) begin
                        state_q <= StFin;
                        fin     <= 1'b1;
                    end
`ifdef REQ_DISPATCH_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= StFin;
                        fin     <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                StFin: begin
                    state_q   <= StIdle;
                    fin       <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    pending_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_req_dispatch.sv
// Self-checking bench for req_dispatch: vector table plus reqs/fin scoreboard, and corner sequences.
module tb_req_dispatch;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [0:0] sel;
    logic [1:0] reqs;
    logic [1:0] dones;
    logic       busy;
    logic       fin;
    logic       err;

    logic       start_b;
    logic [1:0] sel_b;
    logic [2:0] reqs_b;
    logic [2:0] dones_b;
    logic       busy_b;
    logic       fin_b;
    logic       err_b;

    req_dispatch #(.REQ_NUMBER(2), .SEL_WIDTH(1), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rstn(rstn), .start(start), .sel(sel), .reqs(reqs),
        .dones(dones), .busy(busy), .fin(fin), .err(err)
    );

    req_dispatch #(.REQ_NUMBER(3), .SEL_WIDTH(2), .TIMEOUT_CYCLES(10)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .sel(sel_b), .reqs(reqs_b),
        .dones(dones_b), .busy(busy_b), .fin(fin_b), .err(err_b)
    );

    typedef struct {
        int         at;
        logic [1:0] val;
    } req_exp_t;

    typedef struct {
        int   at;
        logic err;
    } fin_exp_t;

    // Offsets are in cycles relative to the cycle start is driven; -1 means unused
    typedef struct {
        logic [1:0] pre;
        logic       sel;
        int         at1;
        logic [1:0] val1;
        int         at2;
        logic [1:0] val2;
        int         ign_at;
        int         len;
        int         fin_at;
        logic       err;
    } vec_t;

    req_exp_t req_q[$];
    fin_exp_t fin_q[$];
    req_exp_t r;
    fin_exp_t f;
    vec_t     vecs[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 2-channel instance: every reqs pulse and fin pulse must match a queued entry
    always @(negedge clk) begin
        if (mon_en) begin
            if (reqs != 2'b00) begin
                if (req_q.size() == 0) begin
                    check("reqs_spurious", 32'(reqs), 32'(0));
                end else begin
                    r = req_q.pop_front();
                    check("reqs_cycle", 32'(cyc), 32'(r.at));
                    check("reqs_value", 32'(reqs), 32'(r.val));
                end
            end
            if (fin) begin
                if (fin_q.size() == 0) begin
                    check("fin_spurious", 32'(fin), 32'(0));
                end else begin
                    f = fin_q.pop_front();
                    check("fin_cycle", 32'(cyc), 32'(f.at));
                    check("fin_err", 32'(err), 32'(f.err));
                end
            end else if (err) begin
                check("err_without_fin", 32'(err), 32'(0));
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int s;
        s = cyc;
        start = 1'b1;
        sel   = v.sel;
        req_q.push_back('{at: s + 1, val: 2'(2'b01 << v.sel)});
        fin_q.push_back('{at: s + v.fin_at, err: v.err});
        for (int o = 1; o <= v.len; o++) begin
            tick();
            start = (o == v.ign_at);
            sel   = ~v.sel;
            if (o == v.at1) dones = v.val1;
            if (o == v.at2) dones = v.val2;
            @(negedge clk);
            check($sformatf("v%0d_busy_o%0d", idx, o), 32'(busy), 32'(o <= v.fin_at));
        end
        start = 1'b0;
        dones = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        int s;
        vecs[0] = '{2'b00, 1'b1, 5, 2'b10, -1, 2'b00, -1, 8, 6, 1'b0};  // nominal
        vecs[1] = '{2'b00, 1'b0, 4, 2'b10, 8, 2'b11, -1, 11, 9, 1'b0};  // wrong channel first
        vecs[2] = '{2'b00, 1'b0, 1, 2'b01, -1, 2'b00, -1, 5, 3, 1'b0};  // edge in ISSUE -> pending
        vecs[3] = '{2'b10, 1'b1, 3, 2'b00, 5, 2'b10, -1, 8, 6, 1'b0};   // level already high
        vecs[4] = '{2'b00, 1'b1, 4, 2'b10, -1, 2'b00, 5, 8, 5, 1'b0};   // start ignored in FIN
        vecs[5] = '{2'b00, 1'b1, 1, 2'b01, 4, 2'b11, -1, 7, 5, 1'b0};   // other channel in ISSUE
        vecs[6] = '{2'b00, 1'b0, 2, 2'b01, -1, 2'b00, 2, 5, 3, 1'b0};   // earliest WAIT edge, start in WAIT

        rstn = 1'b0; start = 1'b0; sel = 1'b0; dones = 2'b00;
        start_b = 1'b0; sel_b = 2'b00; dones_b = 3'b000;
        tick();
        tick();
        @(negedge clk);
        check("rst_reqs", 32'(reqs), 32'(0));
        check("rst_fin", 32'(fin), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_b_reqs", 32'(reqs_b), 32'(0));
        check("rst_b_busy", 32'(busy_b), 32'(0));
        tick();
        rstn   = 1'b1;
        mon_en = 1'b1;
        tick();

        foreach (vecs[i]) begin
            dones = vecs[i].pre;
            tick();
            run_vec(i, vecs[i]);
        end

        // Back-to-back dispatches, second start in the cycle right after fin
        s = cyc;
        start = 1'b1; sel = 1'b0;
        req_q.push_back('{at: s + 1, val: 2'b01});
        fin_q.push_back('{at: s + 3, err: 1'b0});
        tick(); start = 1'b0;
        tick(); dones = 2'b01;
        tick();
        tick(); start = 1'b1; sel = 1'b1; dones = 2'b00;
        req_q.push_back('{at: s + 5, val: 2'b10});
        fin_q.push_back('{at: s + 7, err: 1'b0});
        @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'(0));
        tick(); start = 1'b0;
        tick(); dones = 2'b10;
        tick();
        tick();
        @(negedge clk);
        check("b2b_done_busy", 32'(busy), 32'(0));
        dones = 2'b00;
        tick();
        tick();

        // Reset while waiting aborts silently
        s = cyc;
        start = 1'b1; sel = 1'b1;
        req_q.push_back('{at: s + 1, val: 2'b10});
        tick(); start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'(1));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("abort_reqs", 32'(reqs), 32'(0));
        check("abort_fin", 32'(fin), 32'(0));
        check("abort_err", 32'(err), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        tick();
        tick(); dones = 2'b10;
        repeat (4) tick();
        @(negedge clk);
        check("abort_busy_after", 32'(busy), 32'(0));
        dones = 2'b00;
        tick();

        // Invalid and valid selection on the 3-channel instance
        start_b = 1'b1; sel_b = 2'd3;
        tick(); start_b = 1'b0;
        @(negedge clk);
        check("inv_reqs", 32'(reqs_b), 32'(0));
        check("inv_fin", 32'(fin_b), 32'(1));
        check("inv_err", 32'(err_b), 32'(1));
        check("inv_busy", 32'(busy_b), 32'(1));
        tick();
        @(negedge clk);
        check("inv_fin_end", 32'(fin_b), 32'(0));
        check("inv_err_end", 32'(err_b), 32'(0));
        check("inv_busy_end", 32'(busy_b), 32'(0));
        start_b = 1'b1; sel_b = 2'd2;
        tick(); start_b = 1'b0;
        @(negedge clk);
        check("sel2_reqs", 32'(reqs_b), 32'(3'b100));
        check("sel2_fin_early", 32'(fin_b), 32'(0));
        tick();
        @(negedge clk);
        check("sel2_reqs_pulse", 32'(reqs_b), 32'(0));
        check("sel2_busy", 32'(busy_b), 32'(1));
        dones_b = 3'b100;
        tick();
        @(negedge clk);
        check("sel2_fin", 32'(fin_b), 32'(1));
        check("sel2_err", 32'(err_b), 32'(0));
        dones_b = 3'b000;
        tick();
        tick();

        // No done at all: timeout when enabled, otherwise wait indefinitely
        s = cyc;
        start = 1'b1; sel = 1'b0;
        req_q.push_back('{at: s + 1, val: 2'b01});
`ifdef REQ_DISPATCH_TIMEOUT_EN
        fin_q.push_back('{at: s + 12, err: 1'b1});
`endif
        tick(); start = 1'b0;
        for (int o = 2; o <= 14; o++) begin
            tick();
            @(negedge clk);
`ifdef REQ_DISPATCH_TIMEOUT_EN
            check($sformatf("tmo_busy_o%0d", o), 32'(busy), 32'(o <= 12));
`else
            check($sformatf("wait_busy_o%0d", o), 32'(busy), 32'(1));
`endif
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        tick();

        check("req_q_drained", 32'(req_q.size()), 32'(0));
        check("fin_q_drained", 32'(fin_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_dispatch.md
REQ_DISPATCH -- requirements
Module: req_dispatch

Interface
REQ-001 SHALL have parameter REQ_NUMBER, default 2: number of downstream request/done channel pairs, legal range 1..16.
REQ-002 SHALL have parameter SEL_WIDTH, default 1: width of sel; must satisfy 2^SEL_WIDTH >= REQ_NUMBER.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: wait limit in clocks, legal range 1..65535; used only with REQ_DISPATCH_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: dispatch request, sampled only in IDLE.
REQ-007 SHALL have port sel, input, SEL_WIDTH bits: target channel index, sampled with start.
REQ-008 SHALL have port reqs, output, REQ_NUMBER bits: one-clock request pulse to the selected downstream module.
REQ-009 SHALL have port dones, input, REQ_NUMBER bits: completion signals from downstream modules, synchronous to clk; a rising edge means finished.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port fin, output, 1 bit: one-clock completion pulse.
REQ-012 SHALL have port err, output, 1 bit: high only during a fin pulse that ends an aborted dispatch.

Function
REQ-013 SHALL implement a 4-state FSM with states IDLE, ISSUE, WAIT and FIN, all outputs registered.
REQ-014 SHALL, in IDLE with start=1, latch sel into selQ and go to ISSUE; if sel >= REQ_NUMBER, SHALL go to FIN with err=1 and assert no reqs bit.
REQ-015 SHALL, in ISSUE, drive reqs[selQ]=1 for exactly one clock with all other reqs bits 0, then go to WAIT unconditionally.
REQ-016 SHALL detect done edges every clock as dones & ~donesQ, where donesQ holds the previous cycle's dones.
REQ-017 SHALL, in WAIT, go to FIN on a rising edge of dones[selQ] or when a pending flag is set; edges on other channels SHALL be ignored.
REQ-018 SHALL set the pending flag when a dones[selQ] rising edge occurs during the ISSUE cycle, and clear it on entry to IDLE.
REQ-019 SHALL, in FIN, drive fin=1 for one clock, then go to IDLE.
REQ-020 SHALL provide latency as follows: start at cycle t gives reqs at t+1; a done edge sampled at cycle d (d >= t+2) gives fin at d+1.
REQ-021 SHALL ignore start in all states except IDLE; no queueing.
REQ-022 SHALL treat a done level already high before ISSUE as no edge, and require a fresh rising edge.
REQ-023 SHALL accept a new start in the clock immediately after fin (IDLE), allowing back-to-back dispatches every 4 clocks minimum.

Reset
REQ-024 SHALL, when rstn=0 at a clock edge, force state=IDLE, reqs=0, fin=0, err=0, busy=0, selQ=0, donesQ=0, pending=0 and timeout counter=0.
REQ-025 SHALL abort a dispatch when reset is asserted mid-operation, with no fin and no err issued afterwards.

Configuration
REQ-026 SHALL, with macro REQ_DISPATCH_TIMEOUT_EN defined, count clocks in WAIT from 0; on reaching TIMEOUT_CYCLES without a done edge, go to FIN with err=1.
REQ-027 SHALL clear the timeout counter on every WAIT entry.
REQ-028 SHALL, without REQ_DISPATCH_TIMEOUT_EN, contain no timeout counter, stay in WAIT indefinitely, and assert err only for an invalid sel.

Verification
REQ-029 SHALL cover nominal dispatch: REQ_NUMBER=2, start=1 with sel=1 at cycle 0, dones[1] rising at cycle 5 -> reqs=2'b10 at cycle 1 only, fin=1 at cycle 6, err=0, busy high for cycles 1-6.
REQ-030 SHALL cover wrong channel: sel=0, dones[1] rising at cycle 4 -> no fin; a later dones[0] rising at cycle 8 -> fin at cycle 9.
REQ-031 SHALL cover an early done: dones[0] rising in the ISSUE cycle (cycle 1) -> fin at cycle 3 via the pending flag.
REQ-032 SHALL cover an invalid sel: REQ_NUMBER=3, SEL_WIDTH=2, sel=3 -> reqs stay 0, fin=1 and err=1 at cycle 1.
REQ-033 SHALL cover timeout: macro defined, TIMEOUT_CYCLES=10, no done -> fin=1 and err=1 exactly 10 clocks after WAIT entry.
REQ-034 SHALL cover reset mid-operation: rstn=0 in WAIT at cycle 3 -> all outputs 0 at cycle 4; a later dones edge produces no fin.
